// File: rtl/rom_stream_reader_if.sv
// Output stream bundle of rom_stream_reader.
// Carries data, valid and last forward, and ready back.
interface rom_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/rom_stream_reader.sv
// Walks a contiguous ROM range and streams the words out through a
// 2-entry buffer with a last-beat marker and an end-of-burst done pulse.
module rom_stream_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic                     rom_en,
  output logic [ADDRESS_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  rom_stream_reader_if.master      strm
);

  localparam logic [ADDRESS_WIDTH-1:0] A_ONE =
    ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH:0]   L_ONE =
    (ADDRESS_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH:0]   r_remain;
  logic                     r_rom_en;
  logic [ADDRESS_WIDTH-1:0] r_rom_address;
  logic                     r_en_last;
  logic                     r_rd_vld;
  logic                     r_rd_last;
  logic                     r_done;

  logic [DATA_WIDTH-1:0]    r_buf_data [2];
  logic                     r_buf_last [2];
  logic                     r_wp;
  logic                     r_rp;
  logic [1:0]               r_cnt;

  logic                     w_valid;
  logic                     w_acc;
  logic                     w_cap;
  logic [2:0]               w_load;
  logic                     w_room;
  logic                     w_first;
  logic                     w_issue;
  logic                     w_done_nxt;

  assign w_valid = (r_cnt != 2'd0);
  assign w_acc   = w_valid & strm.out_ready;

  // A word left on rom_data while the buffer is full is held by the
  // ROM itself (no en), so only un-returned reads count as in flight.
  assign w_cap  = r_rd_vld & ((r_cnt != 2'd2) | w_acc);
  assign w_load = {1'b0, r_cnt}
                + {2'b00, r_rom_en}
                - {2'b00, w_acc};
  assign w_room = (w_load < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b0;
    w_issue     = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            w_first     = 1'b1;
            w_state_nxt = (length == L_ONE) ?
                          S_DRAIN : S_READ;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_READ: begin
        if (w_room) begin
          w_issue = 1'b1;
          if (r_remain == L_ONE) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_acc && r_buf_last[r_rp]) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr        <= '0;
      r_remain      <= '0;
      r_rom_en      <= 1'b0;
      r_rom_address <= '0;
      r_en_last     <= 1'b0;
      r_rd_vld      <= 1'b0;
      r_rd_last     <= 1'b0;
      r_done        <= 1'b0;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last[0] <= 1'b0;
      r_buf_last[1] <= 1'b0;
      r_wp          <= 1'b0;
      r_rp          <= 1'b0;
      r_cnt         <= 2'd0;
    end else begin
      r_done <= w_done_nxt;
      if (w_first) begin
        r_rom_en      <= 1'b1;
        r_rom_address <= base_addr;
        r_addr        <= base_addr + A_ONE;
        r_remain      <= length - L_ONE;
        r_en_last     <= (length == L_ONE);
      end else if (w_issue) begin
        r_rom_en      <= 1'b1;
        r_rom_address <= r_addr;
        r_addr        <= r_addr + A_ONE;
        r_remain      <= r_remain - L_ONE;
        r_en_last     <= (r_remain == L_ONE);
      end else begin
        r_rom_en <= 1'b0;
      end
      r_rd_vld <= r_rom_en | (r_rd_vld & ~w_cap);
      if (r_rom_en) begin
        r_rd_last <= r_en_last;
      end
      if (w_cap) begin
        r_buf_data[r_wp] <= rom_data;
        r_buf_last[r_wp] <= r_rd_last;
        r_wp             <= ~r_wp;
      end
      if (w_acc) begin
        r_rp <= ~r_rp;
      end
      r_cnt <= r_cnt
             + {1'b0, w_cap}
             - {1'b0, w_acc};
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign rom_en         = r_rom_en;
  assign rom_address    = r_rom_address;
  assign strm.out_valid = w_valid;
  assign strm.out_data  = r_buf_data[r_rp];
  assign strm.out_last  = w_valid & r_buf_last[r_rp];

endmodule
